// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64 multiply/divide unit. One radix-2 step per
// cycle: shift-add multiply, restoring shift-subtract divide/remainder.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nx;
  logic [6:0]  cnt;
  logic [63:0] acc;      // product accumulator / partial remainder
  logic [63:0] sh;       // multiplier (shifts right) / dividend-quotient (shifts left)
  logic [63:0] dv;       // multiplicand (shifts left) / divisor magnitude
  logic [63:0] res_q;    // result held after the done pulse
  logic        is_div_q, is_rem_q, neg_quo_q, neg_rem_q, word_q, bypass_q;

  // Operand decode at accept time.
  logic        is_div, is_rem, is_sgn, neg_a, neg_b, div_zero, div_ovf, special;
  logic [63:0] ax, bx, az, bz, mag_a, mag_b, spec_val;

  // Per-step datapath and final fix-up.
  logic [64:0] trial;
  logic        ge;
  logic [63:0] acc_step, sh_step, dv_step, quo, rem, raw, fin;

  // Decode the presented op: sign handling, magnitudes, special cases.
  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    is_div   = (op >= 3'd1) && (op <= 3'd4);
    is_rem   = (op == 3'd3) || (op == 3'd4);
    is_sgn   = (op == 3'd1) || (op == 3'd3);
    ax       = word ? {{32{a[31]}}, a[31:0]} : a;
    bx       = word ? {{32{b[31]}}, b[31:0]} : b;
    az       = word ? {32'h0, a[31:0]} : a;
    bz       = word ? {32'h0, b[31:0]} : b;
    neg_a    = is_sgn & ax[63];
    neg_b    = is_sgn & bx[63];
    mag_a    = neg_a ? -ax : az;
    mag_b    = neg_b ? -bx : bz;
    div_zero = is_div && (bz == 64'h0);
    div_ovf  = is_sgn && (bx == '1) &&
               (ax == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special  = div_zero | div_ovf;
    if (is_rem) spec_val = div_zero ? ax : 64'h0;
    else        spec_val = div_zero ? '1 : ax;
  end

  // One radix-2 iteration of whichever operation is in flight.
  always_comb begin
    trial = {acc, sh[63]};
    ge    = trial >= {1'b0, dv};
    if (is_div_q) begin
      acc_step = ge ? (trial[63:0] - dv) : trial[63:0];
      sh_step  = {sh[62:0], ge};
      dv_step  = dv;
    end else begin
      acc_step = sh[0] ? (acc + dv) : acc;
      sh_step  = sh >> 1;
      dv_step  = dv << 1;
    end
  end

  // Sign fix-up and word sign-extension of the finished value.
  always_comb begin
    quo = neg_quo_q ? -sh : sh;
    rem = neg_rem_q ? -acc : acc;
    if (bypass_q || !is_div_q) raw = acc;
    else                       raw = is_rem_q ? rem : quo;
    fin = (word_q && !bypass_q) ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == 7'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand latch, iteration and result capture.
  // NOTE: the datapath registers are reset too, so nothing of an abandoned op survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 7'd0;
      acc       <= 64'h0;
      sh        <= 64'h0;
      dv        <= 64'h0;
      res_q     <= 64'h0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      word_q    <= 1'b0;
      bypass_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          is_div_q  <= is_div;
          is_rem_q  <= is_rem;
          neg_quo_q <= neg_a ^ neg_b;
          neg_rem_q <= neg_a;
          word_q    <= word;
          bypass_q  <= special;
          cnt       <= word ? 7'd32 : 7'd64;
          if (special) begin
            acc <= spec_val;
            sh  <= 64'h0;
            dv  <= 64'h0;
          end else if (is_div) begin
            acc <= 64'h0;
            sh  <= word ? {mag_a[31:0], 32'h0} : mag_a;
            dv  <= mag_b;
          end else begin
            acc <= 64'h0;
            sh  <= bz;
            dv  <= az;
          end
        end
        CALC: if (!flush) begin
          acc <= acc_step;
          sh  <= sh_step;
          dv  <= dv_step;
          cnt <= cnt - 7'd1;
        end
        DONE: if (!flush) res_q <= fin;
        default: ;
      endcase
    end
  end

  // Handshake outputs; the fresh result is shown directly while done is high.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE) && !flush;
    stall  = start & ~done;
    result = done ? fin : res_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed stimulus with a scoreboard of expected results
// and latencies, popped when the unit raises done.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, word, flush;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy, stall, done;
  logic [63:0] result;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] last_res;

  localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
    .a(a), .b(b), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op (this is cycle 0), wait for done, check result/latency/stall,
  // then confirm the held start is not re-accepted and the result is held.
  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input int exp_lat);
    int          cyc = 0;
    bit          got = 1'b0;
    bit          stall_ok;
    logic [63:0] want;
    int          want_lat;
    exp_q.push_back(exp_res);
    lat_q.push_back(exp_lat);
    op = o; word = w; a = x; b = y; start = 1'b1;
    #1;
    stall_ok = (stall === 1'b1) && (done === 1'b0);
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (done === 1'b1) got = 1'b1;
      else if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
    end
    want     = exp_q.pop_front();
    want_lat = lat_q.pop_front();
    check({tag, " done seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " result"}, result, want);
      check({tag, " latency"}, 64'(cyc), 64'(want_lat));
      check({tag, " stall at done"}, 64'(stall), 64'd0);
    end
    check({tag, " stall before done"}, 64'(stall_ok), 64'd1);
    tick();
    check({tag, " no re-accept"}, {62'd0, busy, done}, 64'd0);
    check({tag, " result held"}, result, want);
    last_res = want;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    reset = 1'b1; start = 1'b1; flush = 1'b0; op = MUL; word = 1'b0; a = '0; b = '0;
    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    check("reset stall follows start", 64'(stall), 64'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    tick();

    run_op("mul 7*-3",      MUL,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("divw -7/2",     DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw -7%2",     REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divu 5/0",      DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu 5%0",      REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("div ovf",       DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem ovf",       REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("mulw",          MUL,  1'b1, 64'h1_0000_0003, 64'hDEAD_BEEF_8000_0000, 64'hFFFF_FFFF_8000_0000, 33);
    run_op("divu 100/7",    DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu 100%7",    REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("rem -100%7",    REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("div 100/-7",    DIV,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("op7 as mul",    3'd7, 1'b0, 64'd6, 64'd7, 64'd42, 65);
    run_op("divw by zero",  DIV,  1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remuw by zero", REMU, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    run_op("divw ovf",      DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("divu big",      DIVU, 1'b0, '1, 64'h1_0000_0000, 64'h0000_0000_FFFF_FFFF, 65);
    run_op("remuw",         REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 33);

    // Flush dominates start while idle.
    op = MUL; word = 1'b0; a = 64'd3; b = 64'd3; start = 1'b1; flush = 1'b1;
    tick();
    check("idle flush blocks accept", 64'(busy), 64'd0);
    flush = 1'b0; start = 1'b0;

    // Flush at cycle 10 of a 64-bit DIVU, then a fresh start at cycle 12.
    op = DIVU; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    quiet = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
    end
    check("flush pre cycles in calc", 64'(quiet), 64'd1);
    flush = 1'b1;
    #1;
    check("flush cycle done", 64'(done), 64'd0);
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush idle at 11", {62'd0, busy, done}, 64'd0);
    check("flush result kept", result, last_res);
    tick();
    run_op("after flush", DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

    // Flush in the last CALC cycle must not complete or change result.
    op = DIVU; word = 1'b1; a = 64'd77; b = 64'd5; start = 1'b1;
    for (int c = 1; c <= 32; c++) tick();
    flush = 1'b1;
    #1;
    check("late flush busy", 64'(busy), 64'd1);
    check("late flush done", 64'(done), 64'd0);
    tick();
    flush = 1'b0; start = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    check("late flush no done", 64'(quiet), 64'd1);
    check("late flush result kept", result, last_res);

    // Flush while in DONE suppresses the pulse and keeps the old result.
    op = DIVU; word = 1'b0; a = 64'd9; b = 64'd0; start = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    check("done flush pulse", 64'(done), 64'd0);
    check("done flush result", result, last_res);
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check("done flush after", result, last_res);
    check("done flush idle", 64'(busy), 64'd0);

    // Reset between edges mid-CALC; start held through reset is accepted after.
    op = MUL; word = 1'b0; a = 64'd3; b = 64'd5; start = 1'b1;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset result", result, 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    check("held reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = 64'd0;
    run_op("after reset", MUL, 1'b0, 64'd3, 64'd5, 64'd15, 65);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: the execute stage presents a mul/div operation; held with a/b/op/word stable until done.
REQ-004 SHALL have port op, input, 3 bits: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; values 5-7 are treated as MUL.
REQ-005 SHALL have port word, input, 1 bit: RV64 W-variant; operates on a[31:0]/b[31:0] and sign-extends the 32-bit result.
REQ-006 SHALL have ports a and b, input, 64 bits each: operand 1 (dividend/multiplicand) and operand 2 (divisor/multiplier).
REQ-007 SHALL have port flush, input, 1 bit: kill the in-flight operation.
REQ-008 SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-009 SHALL have port stall, output, 1 bit: execute-stage hold request.
REQ-010 SHALL have port done, output, 1 bit: result valid this cycle; one-cycle pulse.
REQ-011 SHALL have port result, output, 64 bits: operation result, valid when done=1, held afterwards.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch op, word and operands (magnitudes for signed ops, plus result-sign flags), load the iteration counter with N, and go to CALC; N=64 if word=0, N=32 if word=1.
REQ-014 SHALL, in CALC, perform one radix-2 step per cycle (shift-add for MUL, restoring shift-subtract for div/rem), decrement the counter, and enter DONE in the cycle after the counter's last step (counter 1->0).
REQ-015 SHALL give a latency of N+1 cycles from the IDLE accept edge to done=1 (65 cycles for 64-bit, 33 for word).
REQ-016 SHALL, in DONE, drive done=1 and the final result, then return to IDLE unconditionally; a start seen while in DONE is the completing op and SHALL NOT be re-accepted.
REQ-017 SHALL drive stall = start & ~done, combinationally.
REQ-018 SHALL make MUL return the low 64 bits of the product (64-bit case), or the low 32 bits sign-extended (word case).
REQ-019 SHALL apply signed fix-up for DIV/REM: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
REQ-020 SHALL handle divide by zero (divisor == 0 at accept) by skipping CALC and entering DONE next cycle: quotient = all ones, remainder = dividend (both sign-extended when word=1).
REQ-021 SHALL handle signed overflow (DIV/REM, dividend = most-negative, divisor = -1) by skipping CALC: quotient = dividend, remainder = 0.
REQ-022 SHALL, when flush=1 in any state, force IDLE at the next edge, suppress done that cycle, and leave result unchanged; flush dominates start in IDLE (no accept).
REQ-023 SHALL prevent start in CALC from affecting the latched operands.

Reset
REQ-024 SHALL, on reset (asynchronous, active-high), immediately force: state IDLE, counter 0, result 0, done 0, busy 0, internal accumulators 0.
REQ-025 SHALL abandon any in-flight op on reset mid-CALC, with no done pulse after release.
REQ-026 SHALL keep stall following start (done=0) during reset.

Verification
REQ-027 SHALL be verified by: MUL, a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), word=0 -> done on cycle 65 after accept, result=0xFFFF_FFFF_FFFF_FFEB, stall high cycles 0-64, low on 65.
REQ-028 SHALL be verified by: DIV word=1, a=-7, b=2 -> done on cycle 33, result=0xFFFF_FFFF_FFFF_FFFD; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-029 SHALL be verified by: DIVU a=5, b=0 -> done on cycle 1, result=0xFFFF_FFFF_FFFF_FFFF; REMU a=5, b=0 -> result=5.
REQ-030 SHALL be verified by: DIV a=0x8000_0000_0000_0000, b=-1 -> done on cycle 1, result=0x8000_0000_0000_0000; REM -> 0.
REQ-031 SHALL be verified by: flush asserted at cycle 10 of a 64-bit DIVU -> IDLE at cycle 11, no done pulse, result unchanged; a new start at cycle 12 is accepted and completes normally.
REQ-032 SHALL be verified by: reset pulsed mid-CALC (between edges) -> busy=0 and result=0 immediately; start held through the end of reset is accepted on the first edge after reset deasserts.
